// File: rtl/ula_datapath_if.sv
// Bus/control bundle for ula_datapath: the sequencer (master) drives the
// strobes and operands, the datapath (slave) returns bus, accumulator and flags.
interface ula_datapath_if;
    logic        ir_wr;
    logic        ir_re;
    logic        ac_wr;
    logic        ac_re;
    logic        ula_re;
    logic [3:0]  ula_sel;
    logic [15:0] out_mem_instrucao;
    logic [15:0] mbr;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        bus_en;
    logic [15:0] ac;
    logic [3:0]  opcode;
    logic        flagz;
    logic        flagn;

    modport master (
        output ir_wr, ir_re, ac_wr, ac_re, ula_re, ula_sel,
               out_mem_instrucao, mbr, bus_in,
        input  bus_out, bus_en, ac, opcode, flagz, flagn
    );

    modport slave (
        input  ir_wr, ir_re, ac_wr, ac_re, ula_re, ula_sel,
               out_mem_instrucao, mbr, bus_in,
        output bus_out, bus_en, ac, opcode, flagz, flagn
    );
endinterface

// File: rtl/ula_datapath.sv
// Accumulator/IR datapath with a combinational 16-bit ALU driving a shared bus.
// Define ULA_MULDIV_EN to build the multiplier and divider; otherwise MUL/DIV pass ac through.
module ula_datapath #(
    parameter logic [3:0] ADD  = 4'b0010,
    parameter logic [3:0] SUB  = 4'b0011,
    parameter logic [3:0] MUL  = 4'b0100,
    parameter logic [3:0] DIV  = 4'b0101,
    parameter logic [3:0] ANDP = 4'b0110,
    parameter logic [3:0] ORP  = 4'b0111,
    parameter logic [3:0] NOTP = 4'b1000
) (
    input  logic            clock,
    input  logic            reset,
    ula_datapath_if.slave   bus
);
    logic [15:0] ac_q;
    logic [15:0] ir_q;
    logic        flagz_q;
    logic        flagn_q;
    logic [15:0] result;
    logic [15:0] bus_out;
    logic        bus_en;
    logic [15:0] eff_bus;
`ifdef ULA_MULDIV_EN
    logic signed [31:0] product;
    logic signed [15:0] quotient;
`endif

`ifdef ULA_MULDIV_EN
    assign product = $signed(ac_q) * $signed(bus.mbr);

    // Guard the two cases where plain signed division is undefined or overflows.
    always_comb begin
        quotient = '0;
        if (bus.mbr == 16'h0000)
            quotient = '0;
        else if (ac_q == 16'h8000 && bus.mbr == 16'hFFFF)
            quotient = 16'sh8000;
        else
            quotient = $signed(ac_q) / $signed(bus.mbr);
    end
`endif

    always_comb begin
        result = ac_q;
        case (bus.ula_sel)
            ADD:  result = ac_q + bus.mbr;
            SUB:  result = ac_q - bus.mbr;
`ifdef ULA_MULDIV_EN
            MUL:  result = product[15:0];
            DIV:  result = quotient;
`else
            MUL, DIV: result = ac_q;
`endif
            ANDP: result = ac_q & bus.mbr;
            ORP:  result = ac_q | bus.mbr;
            NOTP: result = ~ac_q;
            default: result = ac_q;
        endcase
    end

    always_comb begin
        bus_out = '0;
        if (bus.ula_re)
            bus_out = result;
        else if (bus.ac_re)
            bus_out = ac_q;
        else if (bus.ir_re)
            bus_out = ir_q;
    end

    assign bus_en  = bus.ula_re | bus.ac_re | bus.ir_re;
    assign eff_bus = bus_en ? bus_out : bus.bus_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            ac_q    <= '0;
            ir_q    <= '0;
            flagz_q <= 1'b0;
            flagn_q <= 1'b0;
        end else begin
            if (bus.ac_wr)
                ac_q <= eff_bus;
            if (bus.ir_wr)
                ir_q <= bus.out_mem_instrucao;
            if (bus.ula_re) begin
                flagz_q <= (result == 16'h0000);
                flagn_q <= result[15];
            end
        end
    end

    assign bus.bus_out = bus_out;
    assign bus.bus_en  = bus_en;
    assign bus.ac      = ac_q;
    assign bus.opcode  = ir_q[15:12];
    assign bus.flagz   = flagz_q;
    assign bus.flagn   = flagn_q;
endmodule

// File: tb/tb_ula_datapath.sv
// Self-checking bench for ula_datapath: directed cases plus randomized traffic
// compared against an arithmetic reference model of the accumulator machine.
module tb_ula_datapath;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ula_datapath_if bus();
    ula_datapath dut (.clock(clock), .reset(reset), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] m_ac, m_ir;
    logic        m_z, m_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] alu(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (sel)
            4'h2: r = sa + sb;
            4'h3: r = sa - sb;
`ifdef ULA_MULDIV_EN
            4'h4: r = sa * sb;
            4'h5: r = (sb == 0) ? 0 : sa / sb;
`endif
            4'h6: r = sa & sb;
            4'h7: r = sa | sb;
            4'h8: r = ~sa;
            default: r = sa;
        endcase
        return r[15:0];
    endfunction

    task automatic drive(input logic r, input logic irw, input logic irr, input logic acw,
                         input logic acr, input logic ular, input logic [3:0] sel,
                         input logic [15:0] ins, input logic [15:0] m, input logic [15:0] bi);
        reset                 = r;
        bus.ir_wr             = irw;
        bus.ir_re             = irr;
        bus.ac_wr             = acw;
        bus.ac_re             = acr;
        bus.ula_re            = ular;
        bus.ula_sel           = sel;
        bus.out_mem_instrucao = ins;
        bus.mbr               = m;
        bus.bus_in            = bi;
        #1;
    endtask

    // One clock: compare all outputs against the model mid-cycle, then advance the model.
    task automatic cycle(input string tag);
        logic [15:0] res, bo, eff;
        logic        en;
        @(negedge clock);
        res = alu(bus.ula_sel, m_ac, bus.mbr);
        en  = bus.ula_re | bus.ac_re | bus.ir_re;
        bo  = bus.ula_re ? res : bus.ac_re ? m_ac : bus.ir_re ? m_ir : 16'h0;
        eff = en ? bo : bus.bus_in;
        chk({tag, ".bus_out"}, bus.bus_out, bo);
        chk({tag, ".bus_en"},  bus.bus_en,  en);
        chk({tag, ".ac"},      bus.ac,      m_ac);
        chk({tag, ".opcode"},  bus.opcode,  m_ir[15:12]);
        chk({tag, ".flagz"},   bus.flagz,   m_z);
        chk({tag, ".flagn"},   bus.flagn,   m_n);
        @(posedge clock);
        if (reset) begin
            m_ac = '0; m_ir = '0; m_z = 1'b0; m_n = 1'b0;
        end else begin
            if (bus.ac_wr)  m_ac = eff;
            if (bus.ir_wr)  m_ir = bus.out_mem_instrucao;
            if (bus.ula_re) begin
                m_z = (res == 16'h0);
                m_n = res[15];
            end
        end
        #1;
    endtask

    task automatic load_ac(input logic [15:0] v);
        drive(0, 0, 0, 1, 0, 0, 4'h0, 16'h0, 16'h0, v);
        cycle("ld");
    endtask

    initial begin
        logic [15:0] exp_v;
        drive(1, 0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 16'h0);
        @(posedge clock); #1;
        m_ac = '0; m_ir = '0; m_z = 1'b0; m_n = 1'b0;
        cycle("rst");

        // ADD with simultaneous AC write
        load_ac(16'd5);
        drive(0, 0, 0, 1, 0, 1, 4'h2, 16'h0, 16'hFFF9, 16'h0);
        chk("add.bus", bus.bus_out, 16'hFFFE);
        cycle("add");
        chk("add.ac", bus.ac, 16'hFFFE);
        chk("add.n", bus.flagn, 1'b1);
        chk("add.z", bus.flagz, 1'b0);

        load_ac(16'd9);
        drive(0, 0, 0, 0, 0, 1, 4'h3, 16'h0, 16'd9, 16'h0);
        chk("sub.bus", bus.bus_out, 16'h0);
        cycle("sub");
        chk("sub.z", bus.flagz, 1'b1);
        chk("sub.n", bus.flagn, 1'b0);

        load_ac(16'h0F0F);
        drive(0, 0, 0, 0, 0, 1, 4'h6, 16'h0, 16'h00FF, 16'h0);
        chk("and.bus", bus.bus_out, 16'h000F);
        cycle("and");

        load_ac(16'h7FFF);
        drive(0, 0, 0, 0, 0, 1, 4'h2, 16'h0, 16'h0001, 16'h0);
        chk("wrap.bus", bus.bus_out, 16'h8000);
        cycle("wrap");

        load_ac(16'hFED4);
        drive(0, 0, 0, 0, 0, 1, 4'h4, 16'h0, 16'd200, 16'h0);
`ifdef ULA_MULDIV_EN
        exp_v = 16'h15A0;
`else
        exp_v = 16'hFED4;
`endif
        chk("mul.bus", bus.bus_out, exp_v);
        cycle("mul");

        load_ac(16'd3);
        drive(0, 0, 0, 0, 0, 1, 4'h4, 16'h0, 16'd4, 16'h0);
`ifdef ULA_MULDIV_EN
        exp_v = 16'd12;
`else
        exp_v = 16'd3;
`endif
        chk("mul3.bus", bus.bus_out, exp_v);
        cycle("mul3");

        load_ac(16'hFFF9);
        drive(0, 0, 0, 0, 0, 1, 4'h5, 16'h0, 16'd2, 16'h0);
`ifdef ULA_MULDIV_EN
        exp_v = 16'hFFFD;
`else
        exp_v = 16'hFFF9;
`endif
        chk("div.bus", bus.bus_out, exp_v);
        cycle("div");
        drive(0, 0, 0, 0, 0, 1, 4'h5, 16'h0, 16'h0, 16'h0);
`ifdef ULA_MULDIV_EN
        exp_v = 16'h0;
`else
        exp_v = 16'hFFF9;
`endif
        chk("div0.bus", bus.bus_out, exp_v);
        cycle("div0");
        load_ac(16'h8000);
        drive(0, 0, 0, 0, 0, 1, 4'h5, 16'h0, 16'hFFFF, 16'h0);
        chk("divovf.bus", bus.bus_out, 16'h8000);
        cycle("divovf");

        // IR load, then simultaneous read and write shows old IR
        drive(0, 1, 0, 0, 0, 0, 4'h0, 16'h2ABC, 16'h0, 16'h0);
        cycle("irw");
        chk("ir.opcode", bus.opcode, 4'h2);
        drive(0, 1, 1, 0, 0, 0, 4'h0, 16'h5000, 16'h0, 16'h0);
        chk("irr.bus", bus.bus_out, 16'h2ABC);
        chk("irr.en", bus.bus_en, 1'b1);
        cycle("irrw");
        chk("irrw.opcode", bus.opcode, 4'h5);

        drive(0, 0, 0, 1, 0, 0, 4'h0, 16'h0, 16'h0, 16'h1234);
        cycle("busin");
        chk("busin.ac", bus.ac, 16'h1234);
        drive(1, 1, 0, 1, 0, 1, 4'h8, 16'hF000, 16'h0, 16'h5555);
        cycle("rstov");
        chk("rstov.ac", bus.ac, 16'h0);
        chk("rstov.z", bus.flagz, 1'b0);
        chk("rstov.n", bus.flagn, 1'b0);
        chk("rstov.opc", bus.opcode, 4'h0);

        drive(0, 0, 0, 0, 0, 1, 4'h8, 16'h0, 16'h1234, 16'h0);
        chk("not.bus", bus.bus_out, 16'hFFFF);
        cycle("not");
        chk("not.n", bus.flagn, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] m;
            m = $urandom();
            case ($urandom_range(0, 7))
                0: m = 16'h0;
                1: m = 16'hFFFF;
                default: ;
            endcase
            drive(($urandom_range(0, 31) == 0), $urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), 4'($urandom()), 16'($urandom()), m, 16'($urandom()));
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ula_datapath.md
ULA_DATAPATH -- requirements
Module: ula_datapath

Interface
REQ-001 Parameter ADD, 4'b0010, ula_sel code for addition.
REQ-002 Parameter SUB, 4'b0011, ula_sel code for subtraction.
REQ-003 Parameter MUL, 4'b0100, ula_sel code for multiplication.
REQ-004 Parameter DIV, 4'b0101, ula_sel code for division.
REQ-005 Parameter ANDP, 4'b0110, ula_sel code for bitwise AND.
REQ-006 Parameter ORP, 4'b0111, ula_sel code for bitwise OR.
REQ-007 Parameter NOTP, 4'b1000, ula_sel code for bitwise NOT of ac.
REQ-008 clock  input  1  single clock; all state changes on the rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 ir_wr  input  1  load IR from out_mem_instrucao.
REQ-011 ir_re  input  1  drive IR onto bus.
REQ-012 ac_wr  input  1  load AC from the effective bus.
REQ-013 ac_re  input  1  drive AC onto bus.
REQ-014 ula_re  input  1  drive ALU result onto bus and update flags.
REQ-015 ula_sel  input  4  ALU operation select.
REQ-016 out_mem_instrucao  input  16  instruction memory read data.
REQ-017 mbr  input  16  signed second ALU operand.
REQ-018 bus_in  input  16  bus value from external drivers (MBR, etc.).
REQ-019 bus_out  output  16  value this block drives; 0 when bus_en=0.
REQ-020 bus_en  output  1  high when any of ula_re, ac_re, ir_re is high.
REQ-021 ac  output  16  accumulator contents (signed).
REQ-022 opcode  output  4  ir[15:12], combinational.
REQ-023 flagz, flagn  output  1 each  registered zero/negative flags.

Function
REQ-024 bus_out priority mux: ula_re -> ALU result; else ac_re -> ac; else ir_re -> ir; else 0.
REQ-025 Effective bus = bus_out when bus_en=1, else bus_in.
REQ-026 ac_wr=1 at clock edge: ac <= effective bus (AC load of own ac is a hold).
REQ-027 ir_wr=1 at clock edge: ir <= out_mem_instrucao; ir otherwise holds.
REQ-028 ALU is combinational, 16-bit two's-complement, operands ac and mbr, zero latency to bus_out.
REQ-029 ADD/SUB: ac+mbr / ac-mbr, truncated to 16 bits, wrap on overflow (0x7FFF+1 = 0x8000).
REQ-030 MUL: low 16 bits of signed 32-bit product.
REQ-031 DIV: signed quotient truncated toward zero; mbr=0 gives result 0; -32768/-1 gives -32768.
REQ-032 ANDP/ORP: bitwise ac&mbr / ac|mbr; NOTP: ~ac, mbr ignored.
REQ-033 Any other ula_sel: result = ac (pass-through).
REQ-034 ula_re=1 at clock edge: flagz <= (result==0), flagn <= result[15]; otherwise flags hold.
REQ-035 Simultaneous ula_re and ac_wr: AC captures the ALU result in that cycle, flags update in same edge.
REQ-036 Simultaneous ir_wr and ir_re: bus_out shows old IR; new value visible next cycle.

Reset
REQ-037 reset=1 at clock edge: ac=0, ir=0, flagz=0, flagn=0; overrides ac_wr, ir_wr, ula_re in that cycle.
REQ-038 Combinational outputs (bus_out, bus_en, opcode) follow the reset register values immediately after the reset edge.

Configuration
REQ-039 Macro ULA_MULDIV_EN defined: MUL and DIV implemented per REQ-030/031.
REQ-040 ULA_MULDIV_EN undefined: no multiplier/divider; MUL and DIV codes behave as REQ-033 (result = ac).

Verification
REQ-041 ac=5, mbr=-7, ula_sel=ADD, ula_re=1, ac_wr=1 -> bus_out=-2, next edge ac=-2, flagn=1, flagz=0.
REQ-042 ac=9, mbr=9, SUB -> bus_out=0, flagz=1, flagn=0; ANDP 0x0F0F&0x00FF -> 0x000F.
REQ-043 ac=-300, mbr=200, MUL -> 0x15A0 (low 16 bits of -60000); DIV ac=-7, mbr=2 -> -3; mbr=0 -> 0.
REQ-044 out_mem_instrucao=0x2ABC, ir_wr=1 -> opcode=2; then ir_re=1 -> bus_out=0x2ABC, bus_en=1.
REQ-045 bus_in=0x1234, all re low, ac_wr=1 -> ac=0x1234; then reset=1 with ac_wr=1 -> ac=0, flags 0.
REQ-046 Without ULA_MULDIV_EN: ac=3, mbr=4, MUL -> bus_out=3; NOTP ac=0 -> 0xFFFF, flagn=1.
